// File: rtl/cpld_multirom_if.sv
// rtl/cpld_multirom_if.sv - CPC expansion bus bundle for the multi-ROM mapper
//
// Purpose: groups the edge-connector strobes, address/data and the socket
// select outputs of cpld_multirom into one bundle.
// Signals:
//   adr_hi     A[15:8] from the edge connector
//   ioreq_b    Z80 IORQ, active low
//   wr_b       Z80 WR, active low
//   romen_b    gate-array ROM enable, active low
//   data       Z80 data bus
//   lowrom_en  1: slot 0 also replaces the lower ROM
//   romdis     1: disable internal ROM
//   romoe_b    shared socket output enable, active low
//   slot_cs_b  per-slot chip select, active low
//   cfg_locked 1 while the config port is locked
// Modports: master = CPC side, slave = mapper.
interface cpld_multirom_if #(
  parameter int NSLOTS = 4
);
  logic [7:0]        adr_hi;
  logic              ioreq_b;
  logic              wr_b;
  logic              romen_b;
  logic [7:0]        data;
  logic              lowrom_en;
  logic              romdis;
  logic              romoe_b;
  logic [NSLOTS-1:0] slot_cs_b;
  logic              cfg_locked;

  modport master (
    output adr_hi, ioreq_b, wr_b, romen_b, data, lowrom_en,
    input  romdis, romoe_b, slot_cs_b, cfg_locked
  );

  modport slave (
    input  adr_hi, ioreq_b, wr_b, romen_b, data, lowrom_en,
    output romdis, romoe_b, slot_cs_b, cfg_locked
  );
endinterface

// File: rtl/cpld_multirom.sv
// rtl/cpld_multirom.sv - upper/lower ROM mapper with unlockable slot table
//
// Purpose: maps NSLOTS 16K ROM sockets onto the CPC ROM space. The selected
// ROM number is written to any IO port with A13 low; each slot's ROM number
// is programmed through a key-protected config port.
// Ports:
//   clk    in  CPC clock, all state updates on the rising edge
//   reset  in  synchronous, active-high
//   bus    slave side of cpld_multirom_if (strobes, address, data, selects)
module cpld_multirom #(
  parameter int          NSLOTS       = 4,
  parameter logic [7:0]  DEFAULT_BASE = 8'h01,
  parameter logic [7:0]  CFG_PORT     = 8'hFE,
  parameter logic [7:0]  KEY0         = 8'h55,
  parameter logic [7:0]  KEY1         = 8'hAA
) (
  input logic            clk,
  input logic            reset,
  cpld_multirom_if.slave bus
);

  localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  typedef enum logic [1:0] {LOCKED, UNLK1, OPEN, WDATA} cfg_state_t;

  logic              s_ioreq_b, s_wr_b;
  logic [7:0]        s_adr, s_data;
  logic              iowr_q, first_q;
  logic              iowr_now, iowr_ev, cfg_ev, sel_ok;
  logic [7:0]        romsel_q;
  logic [7:0]        slot_rom [NSLOTS];
  logic [NSLOTS-1:0] slot_en;
  logic [IW-1:0]     idx_q;
  cfg_state_t        state_q, state_d;
  logic [NSLOTS-1:0] hit, win;
  logic              upper, lower, taken, locked_o;

  // Bus sampling. first_q marks the cycle whose sample regs still hold the
  // forced idle value; iowr_q is pre-set from it so a strobe held low across
  // reset deassert never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ioreq_b <= 1'b1;
      s_wr_b    <= 1'b1;
      s_adr     <= 8'h00;
      s_data    <= 8'h00;
      iowr_q    <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      s_ioreq_b <= bus.ioreq_b;
      s_wr_b    <= bus.wr_b;
      s_adr     <= bus.adr_hi;
      s_data    <= bus.data;
      iowr_q    <= iowr_now | first_q;
      first_q   <= 1'b0;
    end
  end

  assign iowr_now = !s_ioreq_b && !s_wr_b;
  assign iowr_ev  = iowr_now && !iowr_q;
  assign cfg_ev   = iowr_ev && (s_adr == CFG_PORT) && s_adr[5];
  assign sel_ok   = (s_data[7:3] == 5'b10000) && (int'(s_data[2:0]) < NSLOTS);

  always_ff @(posedge clk) begin
    if (reset) begin
      romsel_q <= 8'h00;
    end else if (iowr_ev && !s_adr[5]) begin
      romsel_q <= s_data;
    end
  end

  // Config FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Config FSM: next state
  always_comb begin
    state_d = state_q;
    if (cfg_ev) begin
      case (state_q)
        LOCKED:  state_d = (s_data == KEY0) ? UNLK1 : LOCKED;
        UNLK1:   state_d = (s_data == KEY1) ? OPEN : LOCKED;
        OPEN: begin
          if (s_data == 8'h00) begin
            state_d = LOCKED;
          end else if (sel_ok) begin
            state_d = WDATA;
          end
        end
        default: state_d = OPEN;
      endcase
    end
  end

  // Config FSM: outputs (forced locked while reset is held)
  always_comb begin
    locked_o = reset || (state_q == LOCKED);
  end

  // Slot table, written from the WDATA state
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      slot_en <= '1;
      for (int i = 0; i < NSLOTS; i++) begin
        slot_rom[i] <= DEFAULT_BASE + 8'(i);
      end
    end else if (cfg_ev) begin
      if (state_q == OPEN && sel_ok) begin
        idx_q <= s_data[IW-1:0];
      end
      if (state_q == WDATA) begin
        slot_rom[idx_q] <= s_data;
        slot_en[idx_q]  <= (s_data != 8'hFF);
      end
    end
  end

  // Decode uses live A15:14 so selects follow the current bus address.
  always_comb begin
    upper = bus.adr_hi[7] && bus.adr_hi[6];
    lower = !bus.adr_hi[7] && !bus.adr_hi[6];
    hit   = '0;
    win   = '0;
    taken = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      hit[i] = upper && slot_en[i] && (slot_rom[i] == romsel_q);
    end
    hit[0] = hit[0] || (bus.lowrom_en && lower && slot_en[0]);
    for (int i = 0; i < NSLOTS; i++) begin
      if (hit[i] && !taken) begin
        win[i] = 1'b1;
        taken  = 1'b1;
      end
    end
  end

  assign bus.slot_cs_b  = reset ? '1 : ~win;
  assign bus.romdis     = !reset && (|hit);
  assign bus.romoe_b    = reset || bus.romen_b || !(|hit);
  assign bus.cfg_locked = locked_o;

endmodule

// File: tb/tb_cpld_multirom.sv
// tb/tb_cpld_multirom.sv - directed self-checking bench for cpld_multirom
module tb_cpld_multirom;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  cpld_multirom_if #(.NSLOTS(4)) bus ();

  cpld_multirom #(
    .NSLOTS(4),
    .DEFAULT_BASE(8'h01),
    .CFG_PORT(8'hFE),
    .KEY0(8'h55),
    .KEY1(8'hAA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] cs, input logic rd, input logic oe);
    chk({tag, ".cs_b"}, 32'(bus.slot_cs_b), 32'(cs));
    chk({tag, ".romdis"}, 32'(bus.romdis), 32'(rd));
    chk({tag, ".romoe_b"}, 32'(bus.romoe_b), 32'(oe));
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    bus.adr_hi  = a;
    bus.data    = d;
    bus.ioreq_b = 1'b0;
    bus.wr_b    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.ioreq_b = 1'b1;
    bus.wr_b    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.adr_hi = 8'hC0;
  endtask

  task automatic unlock();
    io_write(8'hFE, 8'h55);
    io_write(8'hFE, 8'hAA);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.adr_hi    = 8'hC0;
    bus.ioreq_b   = 1'b1;
    bus.wr_b      = 1'b1;
    bus.romen_b   = 1'b0;
    bus.data      = 8'h00;
    bus.lowrom_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst_forced", 4'b1111, 1'b0, 1'b1);
    chk("rst_locked", 32'(bus.cfg_locked), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("post_rst", 4'b1111, 1'b0, 1'b1);
    chk("post_rst_locked", 32'(bus.cfg_locked), 32'd1);

    // 1: select ROM 2 -> default slot1
    io_write(8'hDF, 8'h02);
    chk_out("t1_sel2", 4'b1101, 1'b1, 1'b0);
    bus.romen_b = 1'b1;
    #1;
    chk("t1_romen_hi", 32'(bus.romoe_b), 32'd1);
    bus.romen_b = 1'b0;
    @(posedge clk);
    #1;

    // 2: long strobe, single event, latency
    io_write(8'hDF, 8'h09);
    chk_out("t2_sel9", 4'b1111, 1'b0, 1'b1);
    bus.adr_hi  = 8'hDF;
    bus.data    = 8'h02;
    bus.ioreq_b = 1'b0;
    bus.wr_b    = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_edge_n", 32'(bus.slot_cs_b), 32'b1111);
    bus.data = 8'h03;
    @(posedge clk);
    #1;
    chk("t2_edge_n1", 32'(bus.slot_cs_b), 32'b1101);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_held", 32'(bus.slot_cs_b), 32'b1101);
    bus.ioreq_b = 1'b1;
    bus.wr_b    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.adr_hi = 8'hC0;
    #1;
    chk("t2_after", 32'(bus.slot_cs_b), 32'b1101);

    // 3: unlock, program slot1=7, relock
    unlock();
    chk("t3_open", 32'(bus.cfg_locked), 32'd0);
    io_write(8'hFE, 8'h81);
    io_write(8'hFE, 8'h07);
    io_write(8'hFE, 8'h00);
    chk("t3_relock", 32'(bus.cfg_locked), 32'd1);
    io_write(8'hDF, 8'h07);
    chk("t3_sel7", 32'(bus.slot_cs_b), 32'b1101);
    io_write(8'hDF, 8'h02);
    chk_out("t3_sel2", 4'b1111, 1'b0, 1'b1);

    // 4: bad second key, then a sequence that must not unlock
    io_write(8'hFE, 8'h55);
    io_write(8'hFE, 8'h13);
    chk("t4_badkey", 32'(bus.cfg_locked), 32'd1);
    io_write(8'hFE, 8'hAA);
    io_write(8'hFE, 8'h80);
    io_write(8'hFE, 8'h07);
    chk("t4_still", 32'(bus.cfg_locked), 32'd1);
    io_write(8'hDF, 8'h07);
    chk("t4_table", 32'(bus.slot_cs_b), 32'b1101);

    // 5: duplicate ROM number, priority, disable with FF
    unlock();
    io_write(8'hFE, 8'h80);
    io_write(8'hFE, 8'h05);
    io_write(8'hFE, 8'h82);
    io_write(8'hFE, 8'h05);
    io_write(8'hFE, 8'h00);
    io_write(8'hDF, 8'h05);
    chk_out("t5_prio", 4'b1110, 1'b1, 1'b0);
    unlock();
    io_write(8'hFE, 8'h80);
    io_write(8'hFE, 8'hFF);
    io_write(8'hFE, 8'h00);
    chk("t5_ff", 32'(bus.slot_cs_b), 32'b1011);
    unlock();
    io_write(8'hFE, 8'h80);
    io_write(8'hFE, 8'h01);
    io_write(8'hFE, 8'h00);

    // 6: lower ROM replacement
    bus.lowrom_en = 1'b1;
    bus.adr_hi    = 8'h00;
    #1;
    chk_out("t6_low", 4'b1110, 1'b1, 1'b0);
    bus.lowrom_en = 1'b0;
    #1;
    chk_out("t6_low_off", 4'b1111, 1'b0, 1'b1);
    bus.adr_hi = 8'hC0;
    @(posedge clk);
    #1;

    // 6: reset while in WDATA, with a strobe held across deassert
    unlock();
    io_write(8'hFE, 8'h81);
    chk("t6_wdata", 32'(bus.cfg_locked), 32'd0);
    bus.adr_hi  = 8'hDF;
    bus.data    = 8'h03;
    bus.ioreq_b = 1'b0;
    bus.wr_b    = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    chk_out("t6_rst", 4'b1111, 1'b0, 1'b1);
    chk("t6_rst_locked", 32'(bus.cfg_locked), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.ioreq_b = 1'b1;
    bus.wr_b    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.adr_hi = 8'hC0;
    #1;
    chk("t6_no_event", 32'(bus.slot_cs_b), 32'b1111);
    chk("t6_locked", 32'(bus.cfg_locked), 32'd1);
    io_write(8'hFE, 8'h07);
    io_write(8'hDF, 8'h02);
    chk("t6_def1", 32'(bus.slot_cs_b), 32'b1101);
    io_write(8'hDF, 8'h04);
    chk("t6_def3", 32'(bus.slot_cs_b), 32'b0111);
    io_write(8'hDF, 8'h01);
    chk("t6_def0", 32'(bus.slot_cs_b), 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
